// File: rtl/dcache_write_buffer_pkg.sv
// dcache_write_buffer_pkg: DDR command encodings, store entry type and beat formatting helpers
package dcache_write_buffer_pkg;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ = 3'b001;
  localparam int LINE_OFS_W = 5;
  localparam int BEAT_W = 128;
  localparam int MASK_W = 16;
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0] we;
  } entry_t;
  function automatic logic [30:0] pack_addr(input logic [29:0] a);
    return {2'b00, a[29:LINE_OFS_W-2], 2'b00};
  endfunction
  function automatic logic [BEAT_W-1:0] beat_data(input entry_t e, input logic b);
    return (e.addr[2] == b) ? BEAT_W'(e.data) << {e.addr[1:0], 5'd0} : '0;
  endfunction
  function automatic logic [MASK_W-1:0] beat_mask(input entry_t e, input logic b);
    return (e.addr[2] == b) ? ~(MASK_W'(e.we) << {e.addr[1:0], 2'd0}) : '1;
  endfunction
endpackage

// File: rtl/dcache_write_buffer_if.sv
// dcache_write_buffer_if: dcache store/check side and DDR request FIFO side of the write buffer
interface dcache_write_buffer_if #(parameter int CNT_W = 3);
  logic wr_valid;
  logic wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0] wr_we;
  logic [31:0] chk_addr;
  logic chk_conflict;
  logic empty;
  logic [CNT_W-1:0] count;
  logic af_wr_en;
  logic [2:0] af_cmd_din;
  logic [30:0] af_addr_din;
  logic af_afull;
  logic wdf_wr_en;
  logic [127:0] wdf_data_din;
  logic [15:0] wdf_mask_din;
  logic wdf_afull;
  modport master (
    output wr_valid, wr_addr, wr_data, wr_we, chk_addr, af_afull, wdf_afull,
    input wr_ready, chk_conflict, empty, count, af_wr_en, af_cmd_din, af_addr_din,
    wdf_wr_en, wdf_data_din, wdf_mask_din
  );
  modport slave (
    input wr_valid, wr_addr, wr_data, wr_we, chk_addr, af_afull, wdf_afull,
    output wr_ready, chk_conflict, empty, count, af_wr_en, af_cmd_din, af_addr_din,
    wdf_wr_en, wdf_data_din, wdf_mask_din
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: store entry queue with per-entry valid bits and a line-address conflict compare
module wb_fifo
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic cpu_clk_g,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  entry_t din,
  input  logic [26:0] chk_line,
  output entry_t head_entry,
  output logic [CNT_W-1:0] count,
  output logic conflict
);
  localparam int PW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head, tail;
  assign head_entry = mem[head];
  // entry payload storage, written at the tail
  always_ff @(posedge cpu_clk_g)
    if (push) mem[tail] <= din;
  // pointers, occupancy and valid bits; pointers wrap naturally at DEPTH
  always_ff @(posedge cpu_clk_g)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      valid <= (valid | (push ? DEPTH'(1) << tail : '0)) & ~(pop ? DEPTH'(1) << head : '0);
    end
  // a draining head stays valid until its pop edge, so it still blocks the fill
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      conflict = conflict | (valid[i] & (mem[i].addr[29:3] == chk_line));
  end
endmodule

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: write-through store buffer issuing one masked two-beat DDR burst per store
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic cpu_clk_g,
  input logic rst,
  dcache_write_buffer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] count;
  entry_t head;
  logic push, pop, go;
  assign bus.wr_ready = count < CNT_W'(DEPTH);
  assign push = bus.wr_valid & bus.wr_ready & (|bus.wr_we);
  assign pop = state == BEAT1;
  assign go = (state == IDLE) & (count != '0) & ~bus.af_afull & ~bus.wdf_afull;
  assign bus.count = count;
  assign bus.empty = count == '0;
  assign bus.af_cmd_din = CMD_WRITE;
  wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .cpu_clk_g(cpu_clk_g),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din('{addr: bus.wr_addr[31:2], data: bus.wr_data, we: bus.wr_we}),
    .chk_line(bus.chk_addr[31:5]),
    .head_entry(head),
    .count(count),
    .conflict(bus.chk_conflict)
  );
  // burst sequencer: outputs are registered alongside the state they belong to
  always_ff @(posedge cpu_clk_g)
    if (rst) begin
      state <= IDLE;
      bus.af_wr_en <= 1'b0;
      bus.wdf_wr_en <= 1'b0;
      bus.af_addr_din <= '0;
      bus.wdf_data_din <= '0;
      bus.wdf_mask_din <= '1;
    end else begin
      state <= go ? BEAT0 : (state == BEAT0) ? BEAT1 : IDLE;
      bus.af_wr_en <= go;
      bus.wdf_wr_en <= go | (state == BEAT0);
      bus.af_addr_din <= pack_addr(head.addr);
      bus.wdf_data_din <= beat_data(head, state == BEAT0);
      bus.wdf_mask_din <= beat_mask(head, state == BEAT0);
    end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: randomized and directed checks against a transaction-level queue model
module tb_dcache_write_buffer;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] we;
  } ent_t;
  logic clk = 0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  ent_t q[$];
  int phase = 0;
  dcache_write_buffer_if #(.CNT_W(3)) bus ();
  dcache_write_buffer #(.DEPTH(4), .CNT_W(3)) dut (.cpu_clk_g(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic [127:0] exp_data(input ent_t e, input int b);
    logic [127:0] x = '0;
    for (int w = 0; w < 4; w++)
      if (int'(e.addr[4]) == b && int'(e.addr[3:2]) == w) x[w*32 +: 32] = e.data;
    return x;
  endfunction
  function automatic logic [15:0] exp_mask(input ent_t e, input int b);
    logic [15:0] x = '1;
    for (int w = 0; w < 4; w++)
      if (int'(e.addr[4]) == b && int'(e.addr[3:2]) == w) x[w*4 +: 4] = ~e.we;
    return x;
  endfunction
  task automatic tick();
    bit conf = 0;
    bit accept, start;
    #1;
    foreach (q[i]) if (q[i].addr[31:5] == bus.chk_addr[31:5]) conf = 1;
    check("count", 128'(bus.count), 128'(q.size()));
    check("empty", 128'(bus.empty), 128'(q.size() == 0));
    check("wr_ready", 128'(bus.wr_ready), 128'(q.size() < 4));
    check("af_wr_en", 128'(bus.af_wr_en), 128'(phase == 1));
    check("wdf_wr_en", 128'(bus.wdf_wr_en), 128'(phase != 0));
    check("chk_conflict", 128'(bus.chk_conflict), 128'(conf));
    if (phase != 0) begin
      check("wdf_data", bus.wdf_data_din, exp_data(q[0], phase - 1));
      check("wdf_mask", 128'(bus.wdf_mask_din), 128'(exp_mask(q[0], phase - 1)));
    end
    if (phase == 1) begin
      check("af_addr", 128'(bus.af_addr_din), 128'(31'((q[0].addr >> 5) * 4)));
      check("af_cmd", 128'(bus.af_cmd_din), 128'(3'b000));
    end
    accept = bus.wr_valid && q.size() < 4;
    start = phase == 0 && q.size() > 0 && !bus.af_afull && !bus.wdf_afull;
    if (rst) begin
      q.delete();
      phase = 0;
    end else begin
      if (phase == 2) void'(q.pop_front());
      if (accept && bus.wr_we != 0) q.push_back('{bus.wr_addr, bus.wr_data, bus.wr_we});
      phase = start ? 1 : (phase == 1) ? 2 : 0;
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    bus.wr_valid = 0;
    repeat (n) tick();
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.wr_valid = 1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_we = w;
    tick();
    bus.wr_valid = 0;
  endtask
  initial begin
    rst = 1;
    bus.wr_valid = 0;
    bus.wr_addr = 0;
    bus.wr_data = 0;
    bus.wr_we = 0;
    bus.chk_addr = 32'hFFFF_FFE0;
    bus.af_afull = 0;
    bus.wdf_afull = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle(2);
    store(32'h0000_0000, 32'h1234_5678, 4'b1111);
    idle(5);
    store(32'h0000_001C, 32'hDEAD_BEEF, 4'b0011);
    idle(5);
    bus.af_afull = 1;
    for (int i = 0; i < 4; i++) store(32'h0000_0100 + 32'(i * 36), 32'hA000_0000 + 32'(i), 4'b1111);
    idle(3);
    bus.af_afull = 0;
    bus.wr_valid = 1;
    bus.wr_addr = 32'h0000_0200;
    bus.wr_data = 32'h5555_AAAA;
    bus.wr_we = 4'b0101;
    repeat (6) tick();
    idle(16);
    bus.chk_addr = 32'h0010_0010;
    store(32'h0010_0004, 32'hCAFE_F00D, 4'b1100);
    idle(6);
    bus.chk_addr = 32'h0000_0000;
    store(32'h0010_0004, 32'hCAFE_F00D, 4'b1100);
    idle(6);
    store(32'h0000_0040, 32'h0BAD_0BAD, 4'b0000);
    idle(2);
    store(32'h0000_0048, 32'h1111_2222, 4'b1111);
    tick();
    rst = 1;
    tick();
    rst = 0;
    idle(4);
    for (int i = 0; i < 400; i++) begin
      bus.wr_valid = $urandom_range(0, 1);
      bus.wr_addr = {20'h00100, 7'($urandom_range(0, 3)), 3'($urandom), 2'b00};
      bus.wr_data = $urandom;
      bus.wr_we = 4'($urandom);
      bus.chk_addr = {20'h00100, 7'($urandom_range(0, 3)), 5'($urandom)};
      bus.af_afull = $urandom_range(0, 4) == 0;
      bus.wdf_afull = $urandom_range(0, 6) == 0;
      rst = $urandom_range(0, 99) == 0;
      tick();
    end
    rst = 0;
    bus.af_afull = 0;
    bus.wdf_afull = 0;
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
